sd_cmd_rx: RTL and testbench

SD_CMD_RX -- requirements
Module: sd_cmd_rx

---
 rtl/sd_cmd_rx.sv | 156 +++++++++++++++
 tb/tb_sd_cmd_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_rx.sv
// SD command-line receiver: deserialises a 48-bit command frame, checks CRC7 and
// framing, and presents index/argument with one-cycle valid/done pulses.
module sd_cmd_rx #(
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DI,
  output logic        isBusy,
  output logic        isValid,
  output logic        isDone,
  output logic [5:0]  index,
  output logic [31:0] argument,
  output logic        crcError,
  output logic        frameError
);

  typedef enum logic [2:0] {IDLE, TXBIT, INDEX, ARG, CRC, END} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [6:0]  crc_q, crc_d;
  logic [6:0]  rcrc_q, rcrc_d;
  logic [5:0]  idx_sh_q, idx_sh_d;
  logic [31:0] arg_sh_q, arg_sh_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [5:0]  index_q, index_d;
  logic [31:0] argument_q, argument_d;
  logic        crc_err_q, crc_err_d;
  logic        frame_err_q, frame_err_d;
  logic        crc_bad;

  // Serial CRC7, generator x^7 + x^3 + 1, one input bit per call.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign crc_bad = CHECK_CRC && (crc_q != rcrc_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    rcrc_d      = rcrc_q;
    idx_sh_d    = idx_sh_q;
    arg_sh_d    = arg_sh_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    index_d     = index_q;
    argument_d  = argument_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE: begin
        if (!DI) begin
          // Start bit: CRC restarts from zero and includes this bit.
          state_d     = TXBIT;
          crc_d       = crc7_step(7'd0, DI);
          crc_err_d   = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      TXBIT: begin
        crc_d = crc7_step(crc_q, DI);
        if (DI) begin
          state_d = INDEX;
          cnt_d   = 5'd5;
        end else begin
          frame_err_d = 1'b1;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      INDEX: begin
        crc_d    = crc7_step(crc_q, DI);
        idx_sh_d = {idx_sh_q[4:0], DI};
        if (cnt_q == 5'd0) begin
          state_d = ARG;
          cnt_d   = 5'd31;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ARG: begin
        crc_d    = crc7_step(crc_q, DI);
        arg_sh_d = {arg_sh_q[30:0], DI};
        if (cnt_q == 5'd0) begin
          state_d = CRC;
          cnt_d   = 5'd6;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      CRC: begin
        rcrc_d = {rcrc_q[5:0], DI};
        if (cnt_q == 5'd0) begin
          state_d = END;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      END: begin
        state_d     = IDLE;
        done_d      = 1'b1;
        frame_err_d = !DI;
        crc_err_d   = crc_bad;
        valid_d     = DI && !crc_bad;
        index_d     = idx_sh_q;
        argument_d  = arg_sh_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      rcrc_q      <= '0;
      idx_sh_q    <= '0;
      arg_sh_q    <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      index_q     <= '0;
      argument_q  <= '0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      rcrc_q      <= rcrc_d;
      idx_sh_q    <= idx_sh_d;
      arg_sh_q    <= arg_sh_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      index_q     <= index_d;
      argument_q  <= argument_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign isBusy     = (state_q != IDLE);
  assign isValid    = valid_q;
  assign isDone     = done_q;
  assign index      = index_q;
  assign argument   = argument_q;
  assign crcError   = crc_err_q;
  assign frameError = frame_err_q;

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Scoreboard bench for sd_cmd_rx: directed frames push expected results, a negedge
// monitor pops and compares on every isDone pulse (CRC-checking and non-checking instances).
module tb_sd_cmd_rx;

  typedef struct {
    int          cyc;
    bit          vld;
    bit          ce;
    bit          fe;
    logic [5:0]  idx;
    logic [31:0] arg;
  } exp_t;

  logic        clk, rst_n, di1, di2;
  logic        busy1, vld1, done1, ce1, fe1;
  logic        busy2, vld2, done2, ce2, fe2;
  logic [5:0]  idx1, idx2;
  logic [31:0] arg1, arg2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t m1, m2;

  sd_cmd_rx u_dut (
    .clk(clk), .rst_n(rst_n), .DI(di1), .isBusy(busy1), .isValid(vld1), .isDone(done1),
    .index(idx1), .argument(arg1), .crcError(ce1), .frameError(fe1)
  );

  sd_cmd_rx #(.CHECK_CRC(1'b0)) u_dut_nocrc (
    .clk(clk), .rst_n(rst_n), .DI(di2), .isBusy(busy2), .isValid(vld2), .isDone(done2),
    .index(idx2), .argument(arg2), .crcError(ce2), .frameError(fe2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input bit v, input bit c, input bit f,
                              input logic [5:0] i, input logic [31:0] a);
    exp_t e;
    e.cyc = 0; e.vld = v; e.ce = c; e.fe = f; e.idx = i; e.arg = a;
    return e;
  endfunction

  // Drives a frame MSB first; an aborted frame (tx=0) stops after the transmission bit.
  task automatic send_frame(input bit which, input logic [5:0] idx, input logic [31:0] arg,
                            input logic [6:0] crc, input bit tx, input bit endb, input exp_t e);
    logic [47:0] fr;
    int nbits;
    fr = {1'b0, tx, idx, arg, crc, endb};
    nbits = tx ? 48 : 2;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (i == 0) begin
        e.cyc = cyc + nbits;
        if (which) q2.push_back(e); else q1.push_back(e);
      end
      if (which) di2 = fr[47-i]; else di1 = fr[47-i];
    end
    @(posedge clk);
    #1;
    di1 = 1'b1;
    di2 = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (vld1 || done1) chk("dut1_valid_implies_done", vld1 & done1, vld1);
      if (done1) begin
        chk("dut1_pending_expect", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          m1 = q1.pop_front();
          chk("dut1_done_cycle", cyc, m1.cyc);
          chk("dut1_isValid", vld1, m1.vld);
          chk("dut1_crcError", ce1, m1.ce);
          chk("dut1_frameError", fe1, m1.fe);
          chk("dut1_index", idx1, m1.idx);
          chk("dut1_argument", arg1, m1.arg);
        end
      end
      if (vld2 || done2) chk("dut2_valid_implies_done", vld2 & done2, vld2);
      if (done2) begin
        chk("dut2_pending_expect", q2.size() > 0, 1);
        if (q2.size() > 0) begin
          m2 = q2.pop_front();
          chk("dut2_done_cycle", cyc, m2.cyc);
          chk("dut2_isValid", vld2, m2.vld);
          chk("dut2_crcError", ce2, m2.ce);
          chk("dut2_frameError", fe2, m2.fe);
          chk("dut2_index", idx2, m2.idx);
          chk("dut2_argument", arg2, m2.arg);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] fr;
    rst_n = 1'b0;
    di1 = 1'b1;
    di2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_isBusy", busy1, 0);
    chk("reset_isValid", vld1, 0);
    chk("reset_isDone", done1, 0);
    chk("reset_index", idx1, 0);
    chk("reset_argument", arg1, 0);
    chk("reset_crcError", ce1, 0);
    chk("reset_frameError", fe1, 0);
    chk("reset_dut2_isBusy", busy2, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(0, 6'd0, 32'h0000_0000, 7'h4A, 1, 1, mk(1, 0, 0, 6'd0, 32'h0));
    send_frame(0, 6'd8, 32'h0000_01AA, 7'h43, 1, 1, mk(1, 0, 0, 6'd8, 32'h1AA));
    repeat (3) @(negedge clk);
    send_frame(0, 6'd8, 32'h0000_01AA, 7'h42, 1, 1, mk(0, 1, 0, 6'd8, 32'h1AA));
    send_frame(1, 6'd8, 32'h0000_01AA, 7'h42, 1, 1, mk(1, 0, 0, 6'd8, 32'h1AA));
    // Abort: flags cleared at start, then frameError; index/argument keep CMD8 values.
    send_frame(0, 6'h3F, 32'hFFFF_FFFF, 7'h7F, 0, 1, mk(0, 0, 1, 6'd8, 32'h1AA));
    repeat (2) @(negedge clk);
    send_frame(0, 6'd0, 32'h0000_0000, 7'h4A, 1, 0, mk(0, 0, 1, 6'd0, 32'h0));
    send_frame(0, 6'd0, 32'h0000_0000, 7'h4A, 1, 1, mk(1, 0, 0, 6'd0, 32'h0));
    send_frame(0, 6'd8, 32'h0000_01AA, 7'h43, 1, 1, mk(1, 0, 0, 6'd8, 32'h1AA));

    fr = {1'b0, 1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b1};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      di1 = fr[47-i];
    end
    @(posedge clk);
    #1;
    chk("midframe_isBusy", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_isBusy", busy1, 0);
    chk("async_reset_isValid", vld1, 0);
    chk("async_reset_isDone", done1, 0);
    chk("async_reset_index", idx1, 0);
    chk("async_reset_argument", arg1, 0);
    chk("async_reset_crcError", ce1, 0);
    chk("async_reset_frameError", fe1, 0);
    di1 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(0, 6'd0, 32'h0000_0000, 7'h4A, 1, 1, mk(1, 0, 0, 6'd0, 32'h0));

    for (int k = 0; k < 200 && (q1.size() + q2.size()) > 0; k++) @(negedge clk);
    chk("outstanding_expectations", q1.size() + q2.size(), 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
